// File: rtl/sprite_compositor.sv
// Sprite compositor: bouncing square sprites over a selectable background, 2-clk pixel pipeline.
// Latency 2 clk hpos/vpos -> rgb; no backpressure. Define SPRITE_COLLIDE_EN for the per-frame collision flag.
module sprite_compositor #(
    parameter int         NUM_SPRITES = 2,
    parameter int         SPRITE_BITS = 7,
    parameter int         H_DISPLAY   = 640,
    parameter int         V_DISPLAY   = 480,
    parameter logic [5:0] TRANSPARENT = 6'b000000
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [9:0]                           hpos,
    input  logic [9:0]                           vpos,
    input  logic                                 visible,
    input  logic [1:0]                           bg_mode,
    input  logic [5:0]                           bg_color,
    input  logic [NUM_SPRITES-1:0]               sprite_en,
    input  logic                                 pause,
    output logic [NUM_SPRITES*2*SPRITE_BITS-1:0] rom_addr,
    input  logic [NUM_SPRITES*6-1:0]             rom_data,
    output logic [5:0]                           rgb,
    output logic                                 collide
);

    localparam int         EDGE  = 1 << SPRITE_BITS;
    localparam logic [9:0] X_MAX = 10'(H_DISPLAY - EDGE);
    localparam logic [9:0] Y_MAX = 10'(V_DISPLAY - EDGE);

    logic [9:0] prev_vpos;
    logic       frame_tick;
    logic       step_en;
    logic [9:0] scroll;

    assign frame_tick = (prev_vpos != 10'd0) && (vpos == 10'd0);
    assign step_en    = frame_tick && !pause;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_vpos <= 10'd0;
            scroll    <= 10'd0;
        end else begin
            prev_vpos <= vpos;
            if (step_en)
                scroll <= scroll + 10'd1;
        end
    end

    // Returns {new_dir, new_pos}; dir 1 means moving towards larger coordinates.
    function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic dir,
                                              input logic [9:0] max_pos);
        logic [10:0] r;
        if (dir && pos == max_pos)
            r = {1'b0, pos - 10'd1};
        else if (!dir && pos == 10'd0)
            r = {1'b1, pos + 10'd1};
        else if (dir)
            r = {1'b1, pos + 10'd1};
        else
            r = {1'b0, pos - 10'd1};
        return r;
    endfunction

    logic [9:0]             x_pos [NUM_SPRITES];
    logic [9:0]             y_pos [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] x_dir;
    logic [NUM_SPRITES-1:0] y_dir;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_pos[i] <= 10'(100 + 120 * i);
                y_pos[i] <= 10'(100 + 40 * i);
                x_dir[i] <= ((i % 2) == 0);
                y_dir[i] <= 1'b1;
            end
        end else if (step_en) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                {x_dir[i], x_pos[i]} <= axis_step(x_pos[i], x_dir[i], X_MAX);
                {y_dir[i], y_pos[i]} <= axis_step(y_pos[i], y_dir[i], Y_MAX);
            end
        end
    end

    // Stage 0: sprite hit test and ROM addressing, straight from the beam position.
    logic [NUM_SPRITES-1:0] hit;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        logic [9:0] x_off;
        logic [9:0] y_off;
        assign x_off  = hpos - x_pos[g];
        assign y_off  = vpos - y_pos[g];
        assign hit[g] = (x_off[9:SPRITE_BITS] == '0) && (y_off[9:SPRITE_BITS] == '0);
        assign rom_addr[g*2*SPRITE_BITS +: 2*SPRITE_BITS] =
            {y_off[SPRITE_BITS-1:0], x_off[SPRITE_BITS-1:0]};
    end

    function automatic logic [5:0] stripe(input logic [9:0] x, input logic [9:0] y);
        return {x[5], y[1], x[6], y[1], x[7], y[1]};
    endfunction

    // Scroll only offsets the coordinates in diagonal mode; other modes see the raw beam.
    logic [9:0] mx;
    logic [9:0] my;
    logic [5:0] bg_pix;

    always_comb begin
        mx = hpos;
        my = vpos;
        if (bg_mode == 2'd3) begin
            mx = hpos + scroll;
            my = vpos + scroll;
        end
        case (bg_mode)
            2'd0:    bg_pix = bg_color;
            2'd2:    bg_pix = stripe(vpos, hpos);
            default: bg_pix = stripe(mx, my);
        endcase
    end

    // Stage 1 registers; ROM data for these addresses arrives alongside them.
    logic [NUM_SPRITES-1:0] s1_hit;
    logic [NUM_SPRITES-1:0] s1_en;
    logic                   s1_vis;
    logic [5:0]             s1_bg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_hit <= '0;
            s1_en  <= '0;
            s1_vis <= 1'b0;
            s1_bg  <= 6'd0;
        end else begin
            s1_hit <= hit;
            s1_en  <= sprite_en;
            s1_vis <= visible;
            s1_bg  <= bg_pix;
        end
    end

    logic [NUM_SPRITES-1:0] opaque;
    logic [5:0]             pix;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_opaque
        assign opaque[g] = s1_hit[g] & s1_en[g] & (rom_data[g*6 +: 6] != TRANSPARENT);
    end

    // Walk from highest to lowest index so the lowest opaque sprite lands last and wins.
    always_comb begin
        pix = s1_bg;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i])
                pix = rom_data[i*6 +: 6];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rgb <= 6'd0;
        else
            rgb <= s1_vis ? pix : 6'd0;
    end

`ifdef SPRITE_COLLIDE_EN
    logic multi_opaque;
    logic sticky;

    // x & (x-1) is nonzero exactly when two or more bits are set.
    assign multi_opaque = s1_vis && ((opaque & (opaque - 1'b1)) != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky  <= 1'b0;
            collide <= 1'b0;
        end else if (frame_tick) begin
            collide <= sticky;
            sticky  <= multi_opaque;
        end else if (multi_opaque) begin
            sticky <= 1'b1;
        end
    end
`else
    assign collide = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: reset, compositing, priority, background modes, motion, pause, collide.
module tb_sprite_compositor;

    localparam int NS = 2;
    localparam int SB = 7;

`ifdef SPRITE_COLLIDE_EN
    localparam logic EXP_COLL = 1'b1;
`else
    localparam logic EXP_COLL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [9:0]        hpos = 10'd0;
    logic [9:0]        vpos = 10'd0;
    logic              visible = 1'b0;
    logic [1:0]        bg_mode = 2'd0;
    logic [5:0]        bg_color = 6'd0;
    logic [NS-1:0]     sprite_en = '0;
    logic              pause = 1'b0;
    logic [NS*2*SB-1:0] rom_addr;
    logic [NS*6-1:0]   rom_data = '0;
    logic [5:0]        rgb;
    logic              collide;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sprite_compositor #(
        .NUM_SPRITES(NS),
        .SPRITE_BITS(SB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hpos     (hpos),
        .vpos     (vpos),
        .visible  (visible),
        .bg_mode  (bg_mode),
        .bg_color (bg_color),
        .sprite_en(sprite_en),
        .pause    (pause),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rgb      (rgb),
        .collide  (collide)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        vpos = 10'd1;
        cyc(1);
        vpos = 10'd0;
        cyc(1);
    endtask

    initial begin
        // Reset state
        cyc(3);
        check("reset_rgb", rgb, 0);
        check("reset_collide", collide, 0);
        check("reset_x0", dut.x_pos[0], 100);
        check("reset_y0", dut.y_pos[0], 100);
        check("reset_x1", dut.x_pos[1], 220);
        check("reset_y1", dut.y_pos[1], 140);
        check("reset_scroll", dut.scroll, 0);
        rst_n = 1'b1;

        // Solid background outside every sprite
        bg_mode = 2'd0; bg_color = 6'h2A; hpos = 10'd50; vpos = 10'd50; visible = 1'b1;
        sprite_en = 2'b11; rom_data = {6'h0C, 6'h3F};
        cyc(2);
        check("bg_solid", rgb, 6'h2A);

        // Top-left corner of sprite 0
        hpos = 10'd100; vpos = 10'd100;
        #1;
        check("rom_addr_s0_corner", rom_addr[2*SB-1:0], 0);
        cyc(2);
        check("sprite0_opaque", rgb, 6'h3F);
        rom_data = {6'h0C, 6'h00};
        cyc(2);
        check("sprite0_transparent", rgb, 6'h2A);

        // Overlap of sprite 0 (100..227,100..227) and sprite 1 (220..347,140..267)
        hpos = 10'd225; vpos = 10'd150; rom_data = {6'h0C, 6'h30};
        #1;
        check("rom_addr_overlap", rom_addr, {14'd1285, 14'd6525});
        cyc(2);
        check("priority_low_index", rgb, 6'h30);
        sprite_en = 2'b10;
        cyc(2);
        check("priority_s0_disabled", rgb, 6'h0C);
        visible = 1'b0;
        cyc(2);
        check("invisible_black", rgb, 6'h00);

        // Stripe backgrounds, sprites off
        visible = 1'b1; sprite_en = 2'b00;
        bg_mode = 2'd1; hpos = 10'd160; vpos = 10'd2;
        cyc(2);
        check("bg_vstripe", rgb, 6'h37);
        bg_mode = 2'd2; hpos = 10'd2; vpos = 10'd160;
        cyc(2);
        check("bg_hstripe", rgb, 6'h37);
        bg_mode = 2'd1;
        cyc(2);
        check("bg_vstripe_swapped", rgb, 6'h00);

        // Collision flag handover across frames (overlap happened above)
        tick();
        check("collide_after_tick1", collide, EXP_COLL);
        tick();
        check("collide_after_tick2", collide, 0);
        check("scroll_two_ticks", dut.scroll, 2);

        // Mid-frame reset restores start positions
        rst_n = 1'b0; vpos = 10'd0;
        cyc(2);
        rst_n = 1'b1;
        check("rereset_x0", dut.x_pos[0], 100);
        check("rereset_scroll", dut.scroll, 0);
        check("rereset_rgb", rgb, 0);

        // Motion: x0 bounces at 512
        repeat (412) tick();
        check("x0_peak_t412", dut.x_pos[0], 512);
        tick();
        check("x0_t413", dut.x_pos[0], 511);
        repeat (28) tick();
        check("x0_t441", dut.x_pos[0], 483);
        check("y0_t441", dut.y_pos[0], 163);
        check("x1_t441", dut.x_pos[1], 221);
        check("y1_t441", dut.y_pos[1], 123);
        check("scroll_t441", dut.scroll, 441);

        // Pause freezes motion and scroll
        pause = 1'b1;
        repeat (10) tick();
        check("pause_x0", dut.x_pos[0], 483);
        check("pause_scroll", dut.scroll, 441);
        pause = 1'b0;
        tick();
        check("resume_x0", dut.x_pos[0], 482);
        check("resume_y0", dut.y_pos[0], 162);
        check("resume_scroll", dut.scroll, 442);

        // Moved sprite 0 seen at its new corner (482,162)
        bg_mode = 2'd0; bg_color = 6'h2A; sprite_en = 2'b01; rom_data = {6'h0C, 6'h3F};
        hpos = 10'd482; vpos = 10'd162;
        cyc(2);
        check("moved_sprite_hit", rgb, 6'h3F);
        hpos = 10'd481;
        cyc(2);
        check("moved_sprite_left_edge", rgb, 6'h2A);

        // Diagonal scroll (scroll=442) vs plain stripes at the same beam position
        sprite_en = 2'b00; hpos = 10'd0; vpos = 10'd1; bg_mode = 2'd3;
        cyc(2);
        check("bg_scroll", rgb, 6'h37);
        bg_mode = 2'd1;
        cyc(2);
        check("bg_mode_switch", rgb, 6'h00);
        check("scroll_kept", dut.scroll, 442);
        check("collide_idle", collide, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
